// File: rtl/piece_pkg.sv
// Shared types and constants for the falling-piece controller: FSM states,
// PS/2 key codes, tetromino identifiers and the rotation mask table.
package piece_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SPAWN = 3'd1,
      ST_FALL  = 3'd2,
      ST_LOCK  = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   localparam logic [7:0] KEY_LEFT   = 8'h1C;
   localparam logic [7:0] KEY_RIGHT  = 8'h23;
   localparam logic [7:0] KEY_ROTATE = 8'h1D;
   localparam logic [7:0] KEY_DROP   = 8'h1B;

   localparam logic [2:0] PT_I = 3'd0;
   localparam logic [2:0] PT_O = 3'd1;
   localparam logic [2:0] PT_T = 3'd2;
   localparam logic [2:0] PT_S = 3'd3;
   localparam logic [2:0] PT_Z = 3'd4;
   localparam logic [2:0] PT_J = 3'd5;
   localparam logic [2:0] PT_L = 3'd6;

   // Bit (r*4+c) is the cell at row r, column c of the 4x4 box; each
   // orientation is pushed to the top-left corner, rotations are clockwise.
   localparam logic [15:0] SHAPE_MASKS [7][4] = '{
      '{16'h000F, 16'h1111, 16'h000F, 16'h1111},
      '{16'h0033, 16'h0033, 16'h0033, 16'h0033},
      '{16'h0027, 16'h0232, 16'h0072, 16'h0131},
      '{16'h0036, 16'h0231, 16'h0036, 16'h0231},
      '{16'h0063, 16'h0132, 16'h0063, 16'h0132},
      '{16'h0071, 16'h0113, 16'h0047, 16'h0322},
      '{16'h0074, 16'h0311, 16'h0017, 16'h0223}
   };

endpackage

// File: rtl/piece_shape_rom.sv
// Combinational shape lookup: tetromino type and rotation to a 4x4 cell mask.
module piece_shape_rom
   import piece_pkg::*;
(
   input  logic [2:0]  piece_type,
   input  logic [1:0]  piece_rot,
   output logic [15:0] mask
);

   // Out-of-range types yield an empty mask so they can never collide.
   always_comb begin
      if (piece_type <= PT_L) begin
         mask = SHAPE_MASKS[piece_type][piece_rot];
      end else begin
         mask = 16'h0000;
      end
   end

endmodule

// File: rtl/piece_ctrl.sv
// Active-piece controller: spawn, gravity, key moves, lock and game over.
// Define PIECE_CTRL_WALL_KICK_EN to let blocked rotations retry one column left/right.
module piece_ctrl
   import piece_pkg::*;
#(
   parameter int BOARD_W     = 10,
   parameter int BOARD_H     = 24,
   parameter int GRAVITY_DIV = 25000000
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         key_valid,
   input  logic [7:0]                   key_code,
   input  logic [BOARD_W*BOARD_H-1:0]   board_occ,
   output logic [$clog2(BOARD_W)-1:0]   piece_x,
   output logic [$clog2(BOARD_H)-1:0]   piece_y,
   output logic [2:0]                   piece_type,
   output logic [1:0]                   piece_rot,
   output logic                         lock_valid,
   output logic                         game_over
);

   localparam int XW = $clog2(BOARD_W);
   localparam int YW = $clog2(BOARD_H);
   localparam int OW = $clog2(BOARD_W*BOARD_H);
   localparam int GW = (GRAVITY_DIV > 1) ? $clog2(GRAVITY_DIV) : 1;

   localparam int C_SPAWN = 0;
   localparam int C_DOWN  = 1;
   localparam int C_LEFT  = 2;
   localparam int C_RIGHT = 3;
   localparam int C_ROT   = 4;
`ifdef PIECE_CTRL_WALL_KICK_EN
   localparam int C_KICK_L = 5;
   localparam int C_KICK_R = 6;
   localparam int N_CAND   = 7;
`else
   localparam int N_CAND   = 5;
`endif

   state_t           state_r;
   logic [XW-1:0]    piece_x_r;
   logic [YW-1:0]    piece_y_r;
   logic [2:0]       piece_type_r;
   logic [1:0]       piece_rot_r;
   logic             lock_valid_r;
   logic             game_over_r;
   logic [2:0]       seq_r;
   logic [GW-1:0]    grav_r;

   logic             grav_fire_s;
   logic [2:0]       cand_type_s [N_CAND];
   logic [1:0]       cand_rot_s  [N_CAND];
   int               cand_x_s    [N_CAND];
   int               cand_y_s    [N_CAND];
   logic [15:0]      mask_s      [N_CAND];
   logic [N_CAND-1:0] hit_s;

   // A cell off the left, right or bottom edge, or on a locked cell, is a hit.
   function automatic logic collides(input logic [15:0] mask, input int x, input int y,
                                     input logic [BOARD_W*BOARD_H-1:0] occ);
      logic hit;
      int   col;
      int   row;
      hit = 1'b0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            col = x + c;
            row = y + r;
            if (mask[4'(r*4 + c)]) begin
               if (col < 0 || col >= BOARD_W || row < 0 || row >= BOARD_H) begin
                  hit = 1'b1;
               end else if (occ[OW'(row*BOARD_W + col)]) begin
                  hit = 1'b1;
               end else begin
                  hit = hit;
               end
            end else begin
               hit = hit;
            end
         end
      end
      return hit;
   endfunction

   assign grav_fire_s = (grav_r == GW'(GRAVITY_DIV - 1));

   // Every candidate position that the next edge might need, evaluated in parallel.
   always_comb begin
      cand_type_s[C_SPAWN] = seq_r;
      cand_rot_s[C_SPAWN]  = 2'd0;
      cand_x_s[C_SPAWN]    = (BOARD_W - 4) / 2;
      cand_y_s[C_SPAWN]    = 0;
      cand_type_s[C_DOWN]  = piece_type_r;
      cand_rot_s[C_DOWN]   = piece_rot_r;
      cand_x_s[C_DOWN]     = int'(piece_x_r);
      cand_y_s[C_DOWN]     = int'(piece_y_r) + 32'sd1;
      cand_type_s[C_LEFT]  = piece_type_r;
      cand_rot_s[C_LEFT]   = piece_rot_r;
      cand_x_s[C_LEFT]     = int'(piece_x_r) - 32'sd1;
      cand_y_s[C_LEFT]     = int'(piece_y_r);
      cand_type_s[C_RIGHT] = piece_type_r;
      cand_rot_s[C_RIGHT]  = piece_rot_r;
      cand_x_s[C_RIGHT]    = int'(piece_x_r) + 32'sd1;
      cand_y_s[C_RIGHT]    = int'(piece_y_r);
      cand_type_s[C_ROT]   = piece_type_r;
      cand_rot_s[C_ROT]    = piece_rot_r + 2'd1;
      cand_x_s[C_ROT]      = int'(piece_x_r);
      cand_y_s[C_ROT]      = int'(piece_y_r);
`ifdef PIECE_CTRL_WALL_KICK_EN
      cand_type_s[C_KICK_L] = piece_type_r;
      cand_rot_s[C_KICK_L]  = piece_rot_r + 2'd1;
      cand_x_s[C_KICK_L]    = int'(piece_x_r) - 32'sd1;
      cand_y_s[C_KICK_L]    = int'(piece_y_r);
      cand_type_s[C_KICK_R] = piece_type_r;
      cand_rot_s[C_KICK_R]  = piece_rot_r + 2'd1;
      cand_x_s[C_KICK_R]    = int'(piece_x_r) + 32'sd1;
      cand_y_s[C_KICK_R]    = int'(piece_y_r);
`endif
   end

   for (genvar i = 0; i < N_CAND; i++) begin : g_cand
      piece_shape_rom u_rom (
         .piece_type (cand_type_s[i]),
         .piece_rot  (cand_rot_s[i]),
         .mask       (mask_s[i])
      );
      assign hit_s[i] = collides(mask_s[i], cand_x_s[i], cand_y_s[i], board_occ);
   end

   // Game FSM; gravity takes precedence over any key arriving in the same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         piece_x_r    <= '0;
         piece_y_r    <= '0;
         piece_type_r <= PT_I;
         piece_rot_r  <= 2'd0;
         lock_valid_r <= 1'b0;
         game_over_r  <= 1'b0;
         seq_r        <= PT_I;
         grav_r       <= '0;
      end else begin
         lock_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_r <= ST_SPAWN;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_SPAWN: begin
               piece_type_r <= seq_r;
               seq_r        <= (seq_r == PT_L) ? PT_I : seq_r + 3'd1;
               piece_rot_r  <= 2'd0;
               piece_x_r    <= XW'((BOARD_W - 4) / 2);
               piece_y_r    <= '0;
               grav_r       <= '0;
               if (hit_s[C_SPAWN]) begin
                  state_r     <= ST_OVER;
                  game_over_r <= 1'b1;
               end else begin
                  state_r <= ST_FALL;
               end
            end
            ST_FALL: begin
               grav_r <= grav_fire_s ? '0 : grav_r + GW'(1);
               if (grav_fire_s || (key_valid && key_code == KEY_DROP)) begin
                  if (!hit_s[C_DOWN]) begin
                     piece_y_r <= piece_y_r + YW'(1);
                  end else begin
                     state_r <= ST_LOCK;
                  end
               end else if (key_valid) begin
                  case (key_code)
                     KEY_LEFT: begin
                        if (piece_x_r != '0 && !hit_s[C_LEFT]) begin
                           piece_x_r <= piece_x_r - XW'(1);
                        end
                     end
                     KEY_RIGHT: begin
                        if (!hit_s[C_RIGHT]) begin
                           piece_x_r <= piece_x_r + XW'(1);
                        end
                     end
                     KEY_ROTATE: begin
                        if (!hit_s[C_ROT]) begin
                           piece_rot_r <= piece_rot_r + 2'd1;
`ifdef PIECE_CTRL_WALL_KICK_EN
                        end else if (piece_x_r != '0 && !hit_s[C_KICK_L]) begin
                           piece_rot_r <= piece_rot_r + 2'd1;
                           piece_x_r   <= piece_x_r - XW'(1);
                        end else if (!hit_s[C_KICK_R]) begin
                           piece_rot_r <= piece_rot_r + 2'd1;
                           piece_x_r   <= piece_x_r + XW'(1);
`endif
                        end
                     end
                     default: begin
                        piece_x_r <= piece_x_r;
                     end
                  endcase
               end
            end
            ST_LOCK: begin
               // Pulse emerges on the edge leaving LOCK, so a reset here suppresses it.
               lock_valid_r <= 1'b1;
               state_r      <= ST_SPAWN;
            end
            ST_OVER: begin
               state_r <= ST_OVER;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign piece_x    = piece_x_r;
   assign piece_y    = piece_y_r;
   assign piece_type = piece_type_r;
   assign piece_rot  = piece_rot_r;
   assign lock_valid = lock_valid_r;
   assign game_over  = game_over_r;

endmodule

// File: tb/tb_piece_ctrl.sv
// Bench for piece_ctrl (BOARD 10x24, GRAVITY_DIV=4): cell-level game model
// compared every cycle, plus directed literal checks.
module tb_piece_ctrl;

   localparam int W = 10;
   localparam int H = 24;
   localparam int DIV = 4;
   localparam int P_IDLE = 0, P_SPAWN = 1, P_FALL = 2, P_LOCK = 3, P_OVER = 4;

   logic            clock = 1'b0;
   logic            reset, start, key_valid;
   logic [7:0]      key_code;
   logic [W*H-1:0]  board_occ;
   logic [3:0]      piece_x;
   logic [4:0]      piece_y;
   logic [2:0]      piece_type;
   logic [1:0]      piece_rot;
   logic            lock_valid, game_over;

   int checks = 0;
   int errors = 0;
   int lv_seen = 0;

   int m_phase, mx, my, mt, mr, m_seq, m_grav, m_nr;
   bit m_lv, m_go, m_fire;
   bit m_valid = 1'b0;

   piece_ctrl #(.BOARD_W(W), .BOARD_H(H), .GRAVITY_DIV(DIV)) dut (
      .clock(clock), .reset(reset), .start(start), .key_valid(key_valid),
      .key_code(key_code), .board_occ(board_occ), .piece_x(piece_x),
      .piece_y(piece_y), .piece_type(piece_type), .piece_rot(piece_rot),
      .lock_valid(lock_valid), .game_over(game_over)
   );

   always #5 clock = ~clock;

   // Spawn orientations drawn as cells; other orientations come from rotating them.
   function automatic logic [15:0] base_shape(input int t);
      case (t)
         0: return 16'h000F;
         1: return 16'h0033;
         2: return 16'h0027;
         3: return 16'h0036;
         4: return 16'h0063;
         5: return 16'h0071;
         6: return 16'h0074;
         default: return 16'h0000;
      endcase
   endfunction

   function automatic logic [15:0] rotate_cw(input logic [15:0] m);
      logic [15:0] o, res;
      int minr, minc;
      o = 16'h0000; res = 16'h0000; minr = 3; minc = 3;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (m[r*4+c]) o[c*4 + (3-r)] = 1'b1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (o[r*4+c]) begin
               if (r < minr) minr = r;
               if (c < minc) minc = c;
            end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (o[r*4+c]) res[(r-minr)*4 + (c-minc)] = 1'b1;
      return res;
   endfunction

   function automatic bit m_hit(input int t, input int rot, input int x, input int y);
      logic [15:0] m;
      m = base_shape(t);
      for (int k = 0; k < rot; k++) m = rotate_cw(m);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (m[r*4+c]) begin
               if (x+c < 0 || x+c >= W || y+r >= H) return 1'b1;
               if (board_occ[(y+r)*W + (x+c)]) return 1'b1;
            end
      return 1'b0;
   endfunction

   // Reference game model, advanced on each rising edge.
   initial forever begin
      @(posedge clock);
      if (reset) begin
         m_phase = P_IDLE; mx = 0; my = 0; mt = 0; mr = 0;
         m_seq = 0; m_grav = 0; m_lv = 1'b0; m_go = 1'b0; m_valid = 1'b1;
      end else begin
         m_lv = 1'b0;
         case (m_phase)
            P_IDLE: if (start) m_phase = P_SPAWN;
            P_SPAWN: begin
               mt = m_seq; m_seq = (m_seq + 1) % 7;
               mr = 0; mx = (W - 4) / 2; my = 0; m_grav = 0;
               if (m_hit(mt, 0, mx, 0)) begin m_phase = P_OVER; m_go = 1'b1; end
               else m_phase = P_FALL;
            end
            P_FALL: begin
               m_fire = (m_grav == DIV - 1);
               m_grav = m_fire ? 0 : m_grav + 1;
               m_nr = (mr + 1) % 4;
               if (m_fire || (key_valid && key_code == 8'h1B)) begin
                  if (!m_hit(mt, mr, mx, my + 1)) my++;
                  else m_phase = P_LOCK;
               end else if (key_valid) begin
                  if (key_code == 8'h1C && mx > 0 && !m_hit(mt, mr, mx - 1, my)) mx--;
                  else if (key_code == 8'h23 && !m_hit(mt, mr, mx + 1, my)) mx++;
                  else if (key_code == 8'h1D) begin
                     if (!m_hit(mt, m_nr, mx, my)) mr = m_nr;
`ifdef PIECE_CTRL_WALL_KICK_EN
                     else if (mx > 0 && !m_hit(mt, m_nr, mx - 1, my)) begin mr = m_nr; mx--; end
                     else if (!m_hit(mt, m_nr, mx + 1, my)) begin mr = m_nr; mx++; end
`endif
                  end
               end
            end
            P_LOCK: begin m_lv = 1'b1; m_phase = P_SPAWN; end
            default: m_phase = m_phase;
         endcase
      end
   end

   // Every-cycle comparison against the model.
   initial forever begin
      @(negedge clock);
      if (m_valid) begin
         checks++;
         if (piece_x !== 4'(mx) || piece_y !== 5'(my) || piece_type !== 3'(mt) ||
             piece_rot !== 2'(mr) || lock_valid !== m_lv || game_over !== m_go) begin
            errors++;
            $display("FAIL model_cmp t=%0t got x=%0d y=%0d type=%0d rot=%0d lv=%0b go=%0b want x=%0d y=%0d type=%0d rot=%0d lv=%0b go=%0b",
                     $time, piece_x, piece_y, piece_type, piece_rot, lock_valid, game_over,
                     mx, my, mt, mr, m_lv, m_go);
         end
         if (lock_valid === 1'b1) lv_seen++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input int exp);
      checks++;
      if (got !== 32'(exp)) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", name, got, exp);
      end
   endtask

   task automatic do_start();
      start = 1'b1; tick(1); start = 1'b0; tick(1);
   endtask

   task automatic do_reset();
      reset = 1'b1; tick(2); reset = 1'b0;
   endtask

   // Keys are issued on a cycle that is not a gravity step.
   task automatic pulse_key(input logic [7:0] code);
      int n = 0;
      while (m_phase == P_FALL && m_grav == DIV - 1 && n < 4) begin tick(1); n++; end
      key_valid = 1'b1; key_code = code; tick(1);
      key_valid = 1'b0; key_code = 8'h00;
   endtask

   initial begin
      int n;
      int ey;
      reset = 1'b1; start = 1'b0; key_valid = 1'b0; key_code = 8'h00; board_occ = '0;
      tick(2);
      chk("reset_x", piece_x, 0);
      chk("reset_type", piece_type, 0);
      chk("reset_lv", lock_valid, 0);
      chk("reset_go", game_over, 0);
      reset = 1'b0;

      // Spawn and gravity cadence
      do_start();
      chk("spawn_type", piece_type, 0);
      chk("spawn_x", piece_x, 3);
      chk("spawn_y", piece_y, 0);
      chk("spawn_rot", piece_rot, 0);
      tick(3);
      chk("grav_y_before", piece_y, 0);
      tick(1);
      chk("grav_y_step1", piece_y, 1);
      tick(4);
      chk("grav_y_step2", piece_y, 2);

      // Right wall for horizontal I
      pulse_key(8'h23); chk("right_x4", piece_x, 4);
      pulse_key(8'h23); chk("right_x5", piece_x, 5);
      pulse_key(8'h23); chk("right_x6", piece_x, 6);
      pulse_key(8'h23); chk("right_wall_x6", piece_x, 6);

      // Gravity step and left key on the same edge
      n = 0;
      while (!(m_phase == P_FALL && m_grav == DIV - 1) && n < 10) begin tick(1); n++; end
      chk("fire_slot_found", n < 10, 1);
      ey = my + 1;
      key_valid = 1'b1; key_code = 8'h1C; tick(1);
      key_valid = 1'b0; key_code = 8'h00;
      chk("same_cycle_y", piece_y, ey);
      chk("same_cycle_x", piece_x, 6);

      // Fall to the floor and lock
      n = 0;
      while (lock_valid !== 1'b1 && n < 400) begin tick(1); n++; end
      chk("lock_seen", lock_valid, 1);
      chk("lock_y", piece_y, 23);
      chk("lock_type", piece_type, 0);
      tick(1);
      chk("lock_pulse_end", lock_valid, 0);
      chk("next_type", piece_type, 1);
      chk("next_y", piece_y, 0);
      tick(2);
      chk("lock_count", lv_seen, 1);

      // Rotation near the right wall
      do_reset();
      do_start();
      pulse_key(8'h1D);
      chk("rot_vertical", piece_rot, 1);
      repeat (6) pulse_key(8'h23);
      chk("vert_x9", piece_x, 9);
      pulse_key(8'h1D);
      chk("rot_x9_rot", piece_rot, 1);
      chk("rot_x9_x", piece_x, 9);
      pulse_key(8'h1C);
      pulse_key(8'h1C);
      chk("vert_x7", piece_x, 7);
      pulse_key(8'h1D);
`ifdef PIECE_CTRL_WALL_KICK_EN
      chk("kick_rot", piece_rot, 2);
      chk("kick_x", piece_x, 6);
`else
      chk("nokick_rot", piece_rot, 1);
      chk("nokick_x", piece_x, 7);
`endif

      // Blocked spawn: game over, start ignored
      reset = 1'b1;
      for (int i = 0; i < 2*W; i++) board_occ[i] = 1'b1;
      tick(2); reset = 1'b0;
      do_start();
      chk("over_go", game_over, 1);
      chk("over_type", piece_type, 0);
      start = 1'b1; key_valid = 1'b1; key_code = 8'h23; tick(1);
      start = 1'b0; key_valid = 1'b0; key_code = 8'h00;
      tick(3);
      chk("over_hold_go", game_over, 1);
      chk("over_hold_type", piece_type, 0);
      chk("over_hold_x", piece_x, 3);

      // Reset arriving in LOCK suppresses the lock pulse
      board_occ = '0;
      do_reset();
      do_start();
      for (int i = W; i < 2*W; i++) board_occ[i] = 1'b1;
      n = 0;
      while (m_phase != P_LOCK && n < 20) begin tick(1); n++; end
      chk("lock_reached", n < 20, 1);
      reset = 1'b1; tick(1);
      chk("reset_in_lock_lv", lock_valid, 0);
      chk("reset_in_lock_x", piece_x, 0);
      reset = 1'b0; board_occ = '0;
      tick(2);
      chk("total_locks", lv_seen, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
